// File: rtl/sequential_divider_pkg.sv
// Shared arithmetic-block definitions: divider FSM state encoding.
package sequential_divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/Full_Subtractor.sv
// Ripple-borrow subtractor: diff = a - b - borrow_in, borrow_out set on underflow.
module Full_Subtractor #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic [WIDTH:0] borrow;

  assign borrow[0] = borrow_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  assign borrow_out = borrow[WIDTH];

endmodule

// File: rtl/sequential_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract divisor.
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             quot_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;
  logic           unused_rem_msb;

  // The partial remainder is always below the divisor, so its MSB is zero on entry.
  assign unused_rem_msb = rem_in[WIDTH];
  assign shifted        = {rem_in[WIDTH-1:0], dividend_bit};

  Full_Subtractor #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a         (shifted),
    .b         ({1'b0, divisor}),
    .borrow_in (1'b0),
    .diff      (diff),
    .borrow_out(borrow)
  );

  assign rem_out  = borrow ? shifted : diff;
  assign quot_bit = ~borrow;

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  if (WIDTH < 2) begin : g_width_check
    $error("sequential_divider: WIDTH must be at least 2");
  end

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  // Dividend shifts out at the top while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_rem;
  logic             step_quot;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in      (rem_q),
    .dividend_bit(dq_q[WIDTH-1]),
    .divisor     (divisor_q),
    .rem_out     (step_rem),
    .quot_bit    (step_quot)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dq_d        = dq_q;
    divisor_d   = divisor_q;
    out_d       = out_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (in2 != '0) begin
            dq_d      = in1;
            divisor_d = in2;
            rem_d     = '0;
            cnt_d     = '0;
            dbz_d     = 1'b0;
            state_d   = StCalc;
          end else begin
            out_d       = '1;
            remainder_d = in1;
            dbz_d       = 1'b1;
            state_d     = StDone;
          end
        end
      end
      StCalc: begin
        rem_d = step_rem;
        dq_d  = {dq_q[WIDTH-2:0], step_quot};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          out_d       = {dq_q[WIDTH-2:0], step_quot};
          remainder_d = step_rem[WIDTH-1:0];
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      dq_q        <= '0;
      divisor_q   <= '0;
      out_q       <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dq_q        <= dq_d;
      divisor_q   <= divisor_d;
      out_q       <= out_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == StCalc) || (state_q == StDone);
  assign done        = (state_q == StDone);
  assign out         = out_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider against a plain-arithmetic reference model.
module tb_sequential_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] in1, in2;
  logic       busy, done, div_by_zero;
  logic [3:0] out, remainder;

  logic       start8;
  logic [7:0] in1_8, in2_8;
  logic       busy8, done8, dbz8;
  logic [7:0] out8, rem8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sequential_divider #(
    .WIDTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in1        (in1),
    .in2        (in2),
    .busy       (busy),
    .done       (done),
    .out        (out),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  sequential_divider #(
    .WIDTH(8)
  ) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .in1        (in1_8),
    .in2        (in2_8),
    .busy       (busy8),
    .done       (done8),
    .out        (out8),
    .remainder  (rem8),
    .div_by_zero(dbz8)
  );

  // Reference: integer division, or all-ones / dividend / flag for a zero divisor.
  // lat is the number of clock edges after the start edge before done is visible.
  function automatic void ref_div(input int unsigned a, input int unsigned b, input int unsigned w,
                                  output int unsigned q, output int unsigned r, output bit z,
                                  output int lat);
    if (b == 0) begin
      q = (1 << w) - 1;
      r = a;
      z = 1'b1;
      lat = 0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
      lat = int'(w);
    end
  endfunction

  task automatic do_div(input logic [3:0] a, input logic [3:0] b, output logic [3:0] q,
                        output logic [3:0] r, output logic z, output int lat,
                        output logic single);
    @(negedge clk);
    in1 = a;
    in2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in1 = 4'($urandom);
    in2 = 4'($urandom);
    lat = -1;
    q = '0;
    r = '0;
    z = 1'b0;
    single = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        q = out;
        r = remainder;
        z = div_by_zero;
        break;
      end
    end
    if (lat >= 0) begin
      @(negedge clk);
      single = (done === 1'b0);
    end
  endtask

  task automatic do_div8(input logic [7:0] a, input logic [7:0] b, output logic [7:0] q,
                         output logic [7:0] r, output logic z, output int lat);
    @(negedge clk);
    in1_8 = a;
    in2_8 = b;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    in1_8 = 8'($urandom);
    in2_8 = 8'($urandom);
    lat = -1;
    q = '0;
    r = '0;
    z = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        lat = n;
        q = out8;
        r = rem8;
        z = dbz8;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    start8 = 1'b0;
    in1 = '0;
    in2 = '0;
    in1_8 = '0;
    in2_8 = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, out, remainder} !== 11'd0) begin
      failures++;
      $display("FAIL reset_w4: got busy=%b done=%b dbz=%b out=%h rem=%h, expected all zero",
               busy, done, div_by_zero, out, remainder);
    end
    checks++;
    if ({busy8, done8, dbz8, out8, rem8} !== 19'd0) begin
      failures++;
      $display("FAIL reset_w8: got busy=%b done=%b dbz=%b out=%h rem=%h, expected all zero",
               busy8, done8, dbz8, out8, rem8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] q, r;
    logic z, single;
    int lat;
    do_div(4'd13, 4'd3, q, r, z, lat, single);
    checks++;
    if (q !== 4'd4 || r !== 4'd1 || z !== 1'b0) begin
      failures++;
      $display("FAIL basic_13_3: got q=%0d r=%0d dbz=%b, expected q=4 r=1 dbz=0", q, r, z);
    end
    checks++;
    if (lat !== 4 || single !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency: got lat=%0d single=%b, expected lat=4 single=1", lat, single);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out !== 4'd4 || remainder !== 4'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold: got out=%0d rem=%0d busy=%b, expected 4 1 0", out, remainder,
               busy);
    end
  endtask

  task automatic test_div_zero();
    logic [3:0] q, r;
    logic z, single;
    int lat;
    do_div(4'd7, 4'd0, q, r, z, lat, single);
    checks++;
    if (q !== 4'hF || r !== 4'd7 || z !== 1'b1) begin
      failures++;
      $display("FAIL div_zero: got q=%h r=%0d dbz=%b, expected q=f r=7 dbz=1", q, r, z);
    end
    checks++;
    if (lat !== 0 || single !== 1'b1) begin
      failures++;
      $display("FAIL div_zero_latency: got lat=%0d single=%b, expected lat=0 single=1", lat,
               single);
    end
  endtask

  task automatic test_corners();
    logic [3:0] av[2] = '{4'd15, 4'd2};
    logic [3:0] bv[2] = '{4'd1, 4'd9};
    logic [3:0] qv[2] = '{4'd15, 4'd0};
    logic [3:0] rv[2] = '{4'd0, 4'd2};
    for (int i = 0; i < 2; i++) begin
      logic [3:0] q, r;
      logic z, single;
      int lat;
      do_div(av[i], bv[i], q, r, z, lat, single);
      checks++;
      if (q !== qv[i] || r !== rv[i] || z !== 1'b0 || lat !== 4) begin
        failures++;
        $display("FAIL corner_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d, expected q=%0d r=%0d 0 4",
                 av[i], bv[i], q, r, z, lat, qv[i], rv[i]);
      end
    end
  endtask

  task automatic test_width8();
    logic [7:0] q, r;
    logic z;
    int lat;
    do_div8(8'd200, 8'd7, q, r, z, lat);
    checks++;
    if (q !== 8'd28 || r !== 8'd4 || z !== 1'b0 || lat !== 8) begin
      failures++;
      $display("FAIL w8_200_7: got q=%0d r=%0d dbz=%b lat=%0d, expected 28 4 0 8", q, r, z, lat);
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a, b;
      int unsigned eq, er;
      bit ez;
      int elat;
      a = 8'($urandom);
      b = (i == 0) ? 8'd0 : 8'($urandom);
      ref_div(a, b, 8, eq, er, ez, elat);
      do_div8(a, b, q, r, z, lat);
      checks++;
      if (q !== eq[7:0] || r !== er[7:0] || z !== ez || lat !== elat) begin
        failures++;
        $display("FAIL w8_rand_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d, expected %0d %0d %b %0d",
                 a, b, q, r, z, lat, eq, er, ez, elat);
      end
    end
  endtask

  task automatic test_ignore_mid_calc();
    int lat = -1;
    logic [3:0] q = '0, r = '0;
    @(negedge clk);
    in1 = 4'd13;
    in2 = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b1;
        in1 = 4'd9;
        in2 = 4'd2;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = n;
        q = out;
        r = remainder;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (q !== 4'd4 || r !== 4'd1 || lat !== 4) begin
      failures++;
      $display("FAIL ignore_mid_calc: got q=%0d r=%0d lat=%0d, expected 4 1 4", q, r, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat = -1;
    int gap = -1;
    logic idle_seen = 1'b0;
    logic [3:0] q = '0, r = '0;
    @(negedge clk);
    in1 = 4'd13;
    in2 = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    // Request is already up during DONE and stays up into the following IDLE cycle.
    start = 1'b1;
    in1 = 4'd9;
    in2 = 4'd2;
    for (int j = 1; j < 20; j++) begin
      @(negedge clk);
      if (j == 1) idle_seen = (busy === 1'b0);
      if (j == 2) start = 1'b0;
      if (done === 1'b1) begin
        gap = j;
        q = out;
        r = remainder;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat !== 4 || gap !== 6 || idle_seen !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_timing: got lat=%0d gap=%0d idle=%b, expected 4 6 1", lat, gap,
               idle_seen);
    end
    checks++;
    if (q !== 4'd4 || r !== 4'd1) begin
      failures++;
      $display("FAIL back_to_back_result: got q=%0d r=%0d, expected 4 1", q, r);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    logic done_seen = 1'b0;
    logic [3:0] q, r;
    logic z, single;
    int lat;
    @(negedge clk);
    in1 = 4'd13;
    in2 = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) done_seen = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, out, remainder} !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid_calc: got busy=%b done=%b dbz=%b out=%h rem=%h, expected zero",
               busy, done, div_by_zero, out, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done: got done/busy activity=%b, expected 0", done_seen);
    end
    do_div(4'd6, 4'd4, q, r, z, lat, single);
    checks++;
    if (q !== 4'd1 || r !== 4'd2 || z !== 1'b0 || lat !== 4) begin
      failures++;
      $display("FAIL reset_recover_6_4: got q=%0d r=%0d dbz=%b lat=%0d, expected 1 2 0 4", q, r,
               z, lat);
    end
  endtask

  task automatic test_exhaustive();
    int order[256];
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      logic [3:0] a, b, q, r;
      logic z, single;
      int lat, elat;
      int unsigned eq, er;
      bit ez;
      pair = 8'(order[i]);
      a = pair[7:4];
      b = pair[3:0];
      ref_div(a, b, 4, eq, er, ez, elat);
      do_div(a, b, q, r, z, lat, single);
      checks++;
      if (q !== eq[3:0] || r !== er[3:0] || z !== ez || lat !== elat || single !== 1'b1) begin
        failures++;
        $display("FAIL exhaustive_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d single=%b, expected %0d %0d %b %0d 1",
                 a, b, q, r, z, lat, single, eq, er, ez, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_corners();
    test_width8();
    test_ignore_mid_calc();
    test_back_to_back();
    test_reset_mid_calc();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits; WIDTH < 2 SHALL raise an elaboration-time $error.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port in1  input  WIDTH  dividend, unsigned.
REQ-006 SHALL have port in2  input  WIDTH  divisor, unsigned.
REQ-007 SHALL have port busy  output  1  high while in CALC or DONE.
REQ-008 SHALL have port done  output  1  single-cycle pulse when results are valid.
REQ-009 SHALL have port out  output  WIDTH  quotient, registered.
REQ-010 SHALL have port remainder  output  WIDTH  remainder, registered.
REQ-011 SHALL have port div_by_zero  output  1  registered flag; set when in2 was zero.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 IDLE: on a rising edge with start=1 and in2!=0, SHALL latch in1 and in2, clear the partial remainder (WIDTH+1 bits) and the iteration counter, clear div_by_zero, and go to CALC.
REQ-014 IDLE: on a rising edge with start=1 and in2==0, SHALL go directly to DONE with out = all ones, remainder = in1, and div_by_zero=1.
REQ-015 CALC: each edge SHALL perform one restoring step, MSB first: shift the next dividend bit into the partial remainder and subtract the divisor; if no borrow, keep the difference and set the quotient bit, else keep the shifted value and clear the quotient bit.
REQ-016 CALC SHALL last exactly WIDTH edges; on the WIDTH-th edge it SHALL write out/remainder and go to DONE.
REQ-017 DONE: done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-018 Latency: for a start sampled at edge k, done SHALL be high during the cycle after edge k+WIDTH (or after edge k for a zero divisor).
REQ-019 out, remainder and div_by_zero SHALL hold their values from DONE until the next accepted start.
REQ-020 start in CALC or DONE SHALL be ignored, with no effect on state or results; input changes during CALC SHALL not affect the result.
REQ-021 Back-to-back: a start sampled in the IDLE cycle immediately after DONE SHALL be accepted, giving a throughput of one division per WIDTH+2 cycles.
REQ-022 Results SHALL satisfy in1 == out*in2 + remainder with remainder < in2 for all in2 != 0.

Reset
REQ-023 rst_n=0 SHALL immediately, independent of clk, force the state to IDLE, and force busy, done, out, remainder, div_by_zero, the counter and the partial remainder to 0.
REQ-024 Reset asserted mid-CALC or mid-DONE SHALL abort the operation with no done pulse; after release the block SHALL accept a new start in the first IDLE cycle.

Structure
REQ-025 The FSM state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) SHALL reside in the shared ALU package/include used by the arithmetic blocks.
REQ-026 The combinational restoring step SHALL be the sub-module div_step, built on Full_Subtractor #(WIDTH+1), with the borrow selecting between restore and difference; the FSM, counter and registers SHALL reside in sequential_divider.

Verification (WIDTH=4 unless noted)
REQ-027 Bench SHALL check that start with 13/3 gives out=4, remainder=1, div_by_zero=0, and done exactly 4 edges after the start edge, for one cycle.
REQ-028 Bench SHALL check that start with 7/0 gives out=4'hF, remainder=7, div_by_zero=1, and done after 1 edge.
REQ-029 Bench SHALL check that 15/1 gives 15 r0, that 2/9 gives 0 r2, and, with WIDTH=8, that 200/7 gives 28 r4.
REQ-030 Bench SHALL check that a start of 9/2 issued mid-CALC of 13/3 is ignored and the result is still 4 r1; a back-to-back 9/2 accepted right after DONE then gives 4 r1 with its done pulse 6 cycles after the first.
REQ-031 Bench SHALL check that rst_n dropped at CALC iteration 2 immediately zeroes all outputs with no done pulse, and that a new start of 6/4 after release gives 1 r2.
REQ-032 Bench SHALL run a randomized check of the REQ-022 identity over all 256 operand pairs at WIDTH=4.
